// File: rtl/credit_gate_pkg.sv
// Shared types and sizing for the credit-gated pipe stage sitting upstream of ConfigCounter.
// Optional macro CREDIT_PIPE_GATE_BYPASS_EN is consumed by credit_pipe_gate, not here.
package credit_gate_pkg;

  localparam int DATA_WIDTH = 144;
  localparam int COUNT_SZ   = 10;
  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int OCC_W      = PTR_W + 1;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [COUNT_SZ-1:0]   count_t;
  typedef logic [PTR_W-1:0]      ptr_t;
  typedef logic [OCC_W-1:0]      occ_t;

  localparam count_t CREDIT_UNIT = count_t'(1);
  localparam occ_t   OCC_FULL    = occ_t'(FIFO_DEPTH);

  // Depth is a power of two, so dropping the carry is the wrap.
  function automatic ptr_t ptr_next(input ptr_t p);
    return p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/credit_pipe_gate_if.sv
// Generic enable/value/ready channel used for every handshake port of credit_pipe_gate.
// The master drives ena and v; the slave answers with rdy.
interface credit_pipe_gate_if #(parameter int W = 1);

  logic         ena;
  logic [W-1:0] v;
  logic         rdy;

  modport master (output ena, output v, input rdy);
  modport slave  (input ena, input v, output rdy);

endinterface

// File: rtl/credit_gate_fifo.sv
// Register FIFO buffering upstream beats; push is ignored when full, pop when empty.
// Occupancy is held one bit wider than the pointers so full and empty never alias.
module credit_gate_fifo
  import credit_gate_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  push,
  input  data_t wr_data,
  input  logic  pop,
  output data_t head,
  output logic  full,
  output logic  empty
);

  data_t mem [FIFO_DEPTH];
  ptr_t  wr_ptr;
  ptr_t  rd_ptr;
  occ_t  count;
  logic  do_push;
  logic  do_pop;

  assign full    = (count == OCC_FULL);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + occ_t'(1);
        2'b01:   count <= count - occ_t'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/credit_pipe_gate.sv
// Credit-gated pipe stage: forwards buffered beats only while ConfigCounter reports credit and
// batches credit returns into increments. Define CREDIT_PIPE_GATE_BYPASS_EN for 0-cycle bypass.
module credit_pipe_gate
  import credit_gate_pkg::*;
(
  input  logic                CLK,
  input  logic                nRST,
  credit_pipe_gate_if.slave   in_enq,
  credit_pipe_gate_if.master  out_enq,
  credit_pipe_gate_if.slave   credit_ret,
  credit_pipe_gate_if.master  cnt_decrement,
  credit_pipe_gate_if.master  cnt_increment,
  input  logic                cnt_positive,
  output logic                stalled
);

  logic   fifo_full;
  logic   fifo_empty;
  logic   fifo_push;
  logic   fifo_pop;
  data_t  fifo_head;
  logic   send_ok;
  logic   fire_head;
  logic   bypass;
  logic   pending_valid;
  count_t pending_ret;
  logic   flush;
  logic   ret_accept;

  assign send_ok   = cnt_positive && out_enq.rdy && cnt_decrement.rdy;
  assign fire_head = !fifo_empty && send_ok;

`ifdef CREDIT_PIPE_GATE_BYPASS_EN
  assign bypass      = fifo_empty && in_enq.ena && send_ok;
  assign out_enq.v   = bypass ? data_t'(in_enq.v) : fifo_head;
`else
  assign bypass      = 1'b0;
  assign out_enq.v   = fifo_head;
`endif

  assign in_enq.rdy  = !fifo_full;
  assign fifo_push   = in_enq.ena && !fifo_full && !bypass;
  assign fifo_pop    = fire_head;

  // Every forwarded beat, buffered or bypassed, consumes exactly one credit.
  assign out_enq.ena       = fire_head || bypass;
  assign cnt_decrement.ena = fire_head || bypass;
  assign cnt_decrement.v   = CREDIT_UNIT;

  credit_gate_fifo u_fifo (
    .CLK     (CLK),
    .nRST    (nRST),
    .push    (fifo_push),
    .wr_data (data_t'(in_enq.v)),
    .pop     (fifo_pop),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign flush             = pending_valid && cnt_increment.rdy;
  assign credit_ret.rdy    = !pending_valid || flush;
  assign ret_accept        = credit_ret.ena && credit_ret.rdy;
  assign cnt_increment.ena = flush;
  assign cnt_increment.v   = pending_ret;

  // A new return arriving on the flush cycle replaces the flushed value rather than summing.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pending_valid <= 1'b0;
      pending_ret   <= '0;
    end else if (ret_accept && (credit_ret.v != '0)) begin
      pending_valid <= 1'b1;
      pending_ret   <= count_t'(credit_ret.v);
    end else if (flush) begin
      pending_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stalled <= 1'b0;
    end else begin
      stalled <= !fifo_empty && !cnt_positive;
    end
  end

endmodule

// File: tb/tb_credit_pipe_gate.sv
// Directed self-checking bench for credit_pipe_gate with a behavioural ConfigCounter stand-in.
// Expected latency follows CREDIT_PIPE_GATE_BYPASS_EN when the bench is built with that macro.
module tb_credit_pipe_gate;
  import credit_gate_pkg::*;

`ifdef CREDIT_PIPE_GATE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic CLK = 1'b0;
  logic nRST;
  logic cnt_positive;
  logic stalled;

  credit_pipe_gate_if #(.W(DATA_WIDTH)) in_if  ();
  credit_pipe_gate_if #(.W(DATA_WIDTH)) out_if ();
  credit_pipe_gate_if #(.W(COUNT_SZ))   ret_if ();
  credit_pipe_gate_if #(.W(COUNT_SZ))   dec_if ();
  credit_pipe_gate_if #(.W(COUNT_SZ))   inc_if ();

  credit_pipe_gate dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .in_enq        (in_if),
    .out_enq       (out_if),
    .credit_ret    (ret_if),
    .cnt_decrement (dec_if),
    .cnt_increment (inc_if),
    .cnt_positive  (cnt_positive),
    .stalled       (stalled)
  );

  always #5 CLK = ~CLK;

  int    n_asserts = 0;
  int    n_fail    = 0;
  int    credits   = 0;
  logic  load_en   = 1'b0;
  int    load_val  = 0;
  int    dec_count = 0;
  int    bad_pair  = 0;
  data_t out_log [$];

  // Stand-in for ConfigCounter: applies the net of increment and decrement each edge.
  assign cnt_positive = (credits > 0);

  always @(posedge CLK) begin
    if (load_en) credits <= load_val;
    else credits <= credits + (inc_if.ena ? int'(inc_if.v) : 0) - (dec_if.ena ? int'(dec_if.v) : 0);
  end

  always @(posedge CLK) begin
    if (out_if.ena) out_log.push_back(out_if.v);
    if (dec_if.ena) dec_count <= dec_count + 1;
    if (out_if.ena && !dec_if.ena) bad_pair <= bad_pair + 1;
  end

  function automatic data_t beat(input int i);
    return {16'hB000 + 16'(i), {4{32'hC0DE0000 + 32'(i)}}};
  endfunction

  function automatic data_t log_at(input int i);
    return (i < out_log.size()) ? out_log[i] : 'x;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bit accepted;
    nRST       = 1'b0;
    in_if.ena  = 1'b0;
    in_if.v    = '0;
    out_if.rdy = 1'b1;
    ret_if.ena = 1'b0;
    ret_if.v   = '0;
    dec_if.rdy = 1'b1;
    inc_if.rdy = 1'b1;
    #2;
    check("rst_in_rdy",  in_if.rdy,   1);
    check("rst_ret_rdy", ret_if.rdy,  1);
    check("rst_out_ena", out_if.ena,  0);
    check("rst_dec_ena", dec_if.ena,  0);
    check("rst_inc_ena", inc_if.ena,  0);
    check("rst_stalled", stalled,     0);
    tick();
    tick();
    nRST = 1'b1;

    // Three credits, five beats: three go out, two stay buffered behind a stall.
    load_en = 1'b1; load_val = 3;
    tick();
    load_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_if.ena = 1'b1;
      in_if.v   = beat(i);
      #1;
      check($sformatf("t1_in_rdy%0d", i), in_if.rdy, 1);
      tick();
    end
    in_if.ena = 1'b0;
    repeat (4) tick();
    check("t1_out_cnt", out_log.size(), 3);
    for (int i = 0; i < 3; i++) check($sformatf("t1_beat%0d", i), log_at(i), beat(i));
    check("t1_dec_cnt", dec_count, 3);
    check("t1_stalled", stalled, 1);
    check("t1_out_idle", out_if.ena, 0);

    // Return two credits: one increment of 2, then the two buffered beats drain.
    ret_if.ena = 1'b1; ret_if.v = 10'd2;
    #1;
    check("t2_ret_rdy", ret_if.rdy, 1);
    tick();
    ret_if.ena = 1'b0;
    #1;
    check("t2_inc_ena", inc_if.ena, 1);
    check("t2_inc_v",   inc_if.v,   2);
    tick();
    check("t2_inc_once", inc_if.ena, 0);
    repeat (4) tick();
    check("t2_out_cnt", out_log.size(), 5);
    check("t2_beat3", log_at(3), beat(3));
    check("t2_beat4", log_at(4), beat(4));
    check("t2_dec_cnt", dec_count, 5);
    check("t2_stalled", stalled, 0);
    check("t2_credits", credits, 0);

    // No credit: fill the buffer, the fifth beat is held off by rdy and not lost.
    for (int i = 5; i < 9; i++) begin
      in_if.ena = 1'b1;
      in_if.v   = beat(i);
      #1;
      check($sformatf("t3_in_rdy%0d", i), in_if.rdy, 1);
      tick();
    end
    in_if.v = beat(9);
    #1;
    check("t3_full_rdy", in_if.rdy, 0);
    repeat (2) tick();
    check("t3_held_rdy", in_if.rdy, 0);
    check("t3_no_out", out_log.size(), 5);
    check("t3_stalled", stalled, 1);
    ret_if.ena = 1'b1; ret_if.v = 10'd5;
    tick();
    ret_if.ena = 1'b0;
    accepted = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (in_if.rdy) begin
        tick();
        accepted = 1'b1;
        break;
      end
      tick();
    end
    in_if.ena = 1'b0;
    check("t3_hold_accept", accepted, 1);
    repeat (8) tick();
    check("t3_out_cnt", out_log.size(), 10);
    for (int i = 5; i < 10; i++) check($sformatf("t3_beat%0d", i), log_at(i), beat(i));
    check("t3_credits", credits, 0);
    check("t3_stall_clr", stalled, 0);

    // Back-to-back returns while the counter refuses increments.
    inc_if.rdy = 1'b0;
    ret_if.ena = 1'b1; ret_if.v = 10'd3;
    #1;
    check("t4_ret_rdy1", ret_if.rdy, 1);
    tick();
    ret_if.v = 10'd4;
    #1;
    check("t4_ret_rdy2", ret_if.rdy, 0);
    check("t4_inc_block", inc_if.ena, 0);
    tick();
    check("t4_ret_still0", ret_if.rdy, 0);
    inc_if.rdy = 1'b1;
    #1;
    check("t4_flush_ena", inc_if.ena, 1);
    check("t4_flush_v",   inc_if.v,   3);
    check("t4_ret_free",  ret_if.rdy, 1);
    tick();
    ret_if.ena = 1'b0;
    #1;
    check("t4_repl_ena", inc_if.ena, 1);
    check("t4_repl_v",   inc_if.v,   4);
    tick();
    ret_if.ena = 1'b1; ret_if.v = 10'd0;
    #1;
    check("t4_zero_rdy", ret_if.rdy, 1);
    tick();
    ret_if.ena = 1'b0;
    #1;
    check("t4_zero_noinc", inc_if.ena, 0);
    check("t4_credits", credits, 7);

    // Two beats and a return pending when reset hits: all of it is dropped.
    out_if.rdy = 1'b0;
    for (int i = 10; i < 12; i++) begin
      in_if.ena = 1'b1;
      in_if.v   = beat(i);
      tick();
    end
    in_if.ena = 1'b0;
    inc_if.rdy = 1'b0;
    ret_if.ena = 1'b1; ret_if.v = 10'd6;
    tick();
    ret_if.ena = 1'b0;
    #2;
    nRST       = 1'b0;
    out_if.rdy = 1'b1;
    inc_if.rdy = 1'b1;
    #1;
    check("t5_out_ena", out_if.ena, 0);
    check("t5_dec_ena", dec_if.ena, 0);
    check("t5_inc_ena", inc_if.ena, 0);
    check("t5_in_rdy",  in_if.rdy,  1);
    check("t5_ret_rdy", ret_if.rdy, 1);
    check("t5_stalled", stalled,    0);
    tick();
    tick();
    nRST = 1'b1;
    repeat (4) tick();
    check("t5_no_beats", out_log.size(), 10);
    check("t5_dec_cnt",  dec_count, 10);
    check("t5_credits",  credits, 7);

    // Single credit, empty buffer: latency depends on the bypass build.
    load_en = 1'b1; load_val = 1;
    tick();
    load_en = 1'b0;
    in_if.ena = 1'b1;
    in_if.v   = beat(12);
    #1;
    check("t6_out_now", out_if.ena, BYP);
    check("t6_dec_now", dec_if.ena, BYP);
    tick();
    in_if.ena = 1'b0;
    #1;
    check("t6_out_next", out_if.ena, !BYP);
    check("t6_dec_v", dec_if.v, 1);
    tick();
    check("t6_out_cnt", out_log.size(), 11);
    check("t6_beat12", log_at(10), beat(12));
    check("t6_credits", credits, 0);
    check("pair_violations", bad_pair, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
